alu_exec: RTL and testbench
===========================

// Module: alu_exec
// PURPOSE
//  Execute stage directly downstream of the register file. Takes rd1/rd2 (or an
//  immediate), computes the ALU result and registers it with the writeback
//  controls (dest addr, regwrite, memtoreg) for the writeback/regfile write port.
//  Uses a valid/ready handshake on both sides; an optional multi-cycle multiply.
// PARAMETERS
//  DW  8  datapath width (rd1, rd2, imm, result)
//  AW  3  register address width (dst, wa_out)
// PORTS
//  clk           in   1   clock, all state updates on rising edge
//  rst_n         in   1   reset, asynchronous, active-low
//  in_valid      in   1   operand/op bundle valid
//  in_ready      out  1   stage accepts bundle this cycle
//  op            in   3   000 ADD,001 SUB,010 AND,011 OR,100 XOR,101 SLTU,110 SHL,111 MUL/MOV
//  rd1           in   DW  operand A (regfile read port 1)
//  rd2           in   DW  operand B source when alusrc=0
//  imm           in   DW  operand B source when alusrc=1
//  alusrc        in   1   B select
//  dst           in   AW  destination register
//  regwrite_in   in   1   writeback enable for this bundle
//  memtoreg_in   in   1   writeback data select, passed through
//  out_valid     out  1   result registered and valid
//  out_ready     in   1   downstream consumes result this cycle
//  result        out  DW  registered ALU result
//  wa_out        out  AW  registered dst
//  regwrite_out  out  1   out_valid & out_ready & registered regwrite_in
//  memtoreg_out  out  1   registered memtoreg_in
//  zero          out  1   registered (result==0)
//  carry         out  1   ADD carry-out / SUB borrow; 0 for other ops
//  busy          out  1   FSM in MUL
// BEHAVIOUR
//  - Reset: all outputs and registers 0, state IDLE; in_ready=1 once rst_n high.
//  - FSM: IDLE -> MUL (accepted op=111, MUL_EN defined) -> IDLE after 8 iterations.
//  - in_ready = (state==IDLE) & (!out_valid | out_ready), combinational.
//  - Accept = in_valid & in_ready. Single-cycle op accepted at edge N:
//    result/flags/controls loaded and out_valid=1 after edge N (latency 1).
//  - Result held stable while out_valid & !out_ready (backpressure).
//  - out_valid & out_ready with no accept: out_valid clears next edge.
//  - Simultaneous drain + single-cycle accept: new result replaces old, out_valid
//    stays 1, no bubble.
//  - Arithmetic mod 2^DW. SUB: carry=1 iff rd1<B unsigned. SLTU: result={0..,A<B}.
//    SHL: A << B[2:0]. Logic ops carry=0. zero computed from the final result.
// CONFIGURATION
//  ALU_MUL_EN defined: op 111 = MUL, low DW bits of A*B via shift-add, one bit per
//    cycle; accept at edge N, busy=1 edges N..N+7, out_valid after edge N+8
//    (latency 9), carry=0. Old result drains normally while busy; in_ready=0 in MUL.
//  ALU_MUL_EN undefined: op 111 = MOV (result=B), single-cycle; busy tied 0.
//  - rst_n low mid-MUL aborts: state IDLE, out_valid 0, partial product discarded.
// TESTING
//  1 ADD rd1=200,rd2=100 -> next cycle result=44, carry=1, zero=0, out_valid=1.
//  2 SUB rd1=5,imm=5,alusrc=1 -> result=0, zero=1, carry=0.
//  3 out_ready=0 after ADD 3+4 -> result=7 held, in_ready=0, regwrite_out=0
//    until out_ready=1; then regwrite_out=1 for one cycle with wa_out=dst.
//  4 Back-to-back ADD stream, out_ready=1 -> one result per cycle, no bubbles.
//  5 ALU_MUL_EN: MUL 13*11 -> 143 after 9 cycles; 20*20 -> 144; in_ready=0 while busy.
//  6 rst_n pulsed low during MUL cycle 4 -> out_valid=0, busy=0, in_ready=1 after
//    release; no stale writeback. Without ALU_MUL_EN: op 111, rd2=45 -> result=45.

Source files
------------

// File: rtl/alu_exec.sv
// Execute stage: ALU on rd1 and rd2/imm, registered result plus writeback controls,
// valid/ready on both sides. Define ALU_MUL_EN to turn op 111 into an 8-iteration shift-add MUL.
module alu_exec #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    op,
    input  logic [DW-1:0] rd1,
    input  logic [DW-1:0] rd2,
    input  logic [DW-1:0] imm,
    input  logic          alusrc,
    input  logic [AW-1:0] dst,
    input  logic          regwrite_in,
    input  logic          memtoreg_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] result,
    output logic [AW-1:0] wa_out,
    output logic          regwrite_out,
    output logic          memtoreg_out,
    output logic          zero,
    output logic          carry,
    output logic          busy
);
    logic          r_out_valid;
    logic [DW-1:0] r_result;
    logic [AW-1:0] r_wa;
    logic          r_regwrite;
    logic          r_memtoreg;
    logic          r_zero;
    logic          r_carry;

    logic [DW-1:0] w_b;
    logic [DW-1:0] w_res;
    logic          w_carry;
    logic          w_idle;
    logic          w_single;
    logic          w_accept;

    always_comb begin
        w_b     = alusrc ? imm : rd2;
        w_res   = '0;
        w_carry = 1'b0;
        case (op)
            3'b000: {w_carry, w_res} = {1'b0, rd1} + {1'b0, w_b};
            3'b001: {w_carry, w_res} = {1'b0, rd1} - {1'b0, w_b};
            3'b010: w_res = rd1 & w_b;
            3'b011: w_res = rd1 | w_b;
            3'b100: w_res = rd1 ^ w_b;
            3'b101: w_res = {{(DW-1){1'b0}}, (rd1 < w_b)};
            3'b110: w_res = rd1 << w_b[2:0];
            default: w_res = w_b;  // MOV; ignored when op 111 is the multiplier
        endcase
    end

`ifdef ALU_MUL_EN
    typedef enum logic {S_IDLE, S_MUL} state_t;
    state_t        r_state;
    logic [DW-1:0] r_ma;
    logic [DW-1:0] r_mb;
    logic [DW-1:0] r_acc;
    logic [2:0]    r_cnt;
    logic [AW-1:0] r_m_dst;
    logic          r_m_rw;
    logic          r_m_mr;
    logic [DW-1:0] w_mul_acc;
    logic          w_mul_done;

    assign w_idle     = (r_state == S_IDLE);
    assign w_single   = (op != 3'b111);
    assign w_mul_acc  = r_acc + (r_mb[0] ? r_ma : '0);
    // Final iteration lands straight in the output register; it waits if the slot is still held.
    assign w_mul_done = (r_state == S_MUL) && (r_cnt == 3'd7) && (!r_out_valid || out_ready);
    assign busy       = (r_state == S_MUL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ma    <= '0;
            r_mb    <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_m_dst <= '0;
            r_m_rw  <= 1'b0;
            r_m_mr  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept && !w_single) begin
                    r_state <= S_MUL;
                    r_ma    <= rd1;
                    r_mb    <= w_b;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    r_m_dst <= dst;
                    r_m_rw  <= regwrite_in;
                    r_m_mr  <= memtoreg_in;
                end
                S_MUL: begin
                    if (r_cnt != 3'd7) begin
                        r_acc <= w_mul_acc;
                        r_ma  <= r_ma << 1;
                        r_mb  <= r_mb >> 1;
                        r_cnt <= r_cnt + 3'd1;
                    end else if (w_mul_done) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
`else
    assign w_idle   = 1'b1;
    assign w_single = 1'b1;
    assign busy     = 1'b0;
`endif

    assign in_ready = w_idle && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_wa        <= '0;
            r_regwrite  <= 1'b0;
            r_memtoreg  <= 1'b0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
        end else if (w_accept && w_single) begin
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_wa        <= dst;
            r_regwrite  <= regwrite_in;
            r_memtoreg  <= memtoreg_in;
            r_zero      <= (w_res == '0);
            r_carry     <= w_carry;
`ifdef ALU_MUL_EN
        end else if (w_mul_done) begin
            r_out_valid <= 1'b1;
            r_result    <= w_mul_acc;
            r_wa        <= r_m_dst;
            r_regwrite  <= r_m_rw;
            r_memtoreg  <= r_m_mr;
            r_zero      <= (w_mul_acc == '0);
            r_carry     <= 1'b0;
`endif
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid    = r_out_valid;
    assign result       = r_result;
    assign wa_out       = r_wa;
    assign regwrite_out = r_out_valid && out_ready && r_regwrite;
    assign memtoreg_out = r_memtoreg;
    assign zero         = r_zero;
    assign carry        = r_carry;
endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: directed spec cases plus a randomized handshake run scored
// against an arithmetic reference queue. Follows ALU_MUL_EN like the design.
module tb_alu_exec;
    localparam int DW = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready;
    logic [2:0]    op;
    logic [DW-1:0] rd1, rd2, imm;
    logic          alusrc;
    logic [AW-1:0] dst;
    logic          regwrite_in, memtoreg_in;
    logic          out_valid, out_ready;
    logic [DW-1:0] result;
    logic [AW-1:0] wa_out;
    logic          regwrite_out, memtoreg_out, zero, carry, busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int res;
        int c;
        int wa;
        int rw;
        int mr;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    alu_exec #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rd1(rd1), .rd2(rd2), .imm(imm), .alusrc(alusrc),
        .dst(dst), .regwrite_in(regwrite_in), .memtoreg_in(memtoreg_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .wa_out(wa_out),
        .regwrite_out(regwrite_out), .memtoreg_out(memtoreg_out),
        .zero(zero), .carry(carry), .busy(busy)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference ALU in plain integer arithmetic.
    function automatic void model(input int o, input int a, input int b,
                                  output int r, output int c);
        c = 0;
        case (o)
            0: begin r = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
            1: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (a < b) ? 1 : 0;
            6: r = (a * (1 << (b % 8))) % 256;
`ifdef ALU_MUL_EN
            default: r = (a * b) % 256;
`else
            default: r = b;
`endif
        endcase
    endfunction

    task automatic send(input int o, input int a, input int b2, input int im,
                        input bit src, input int d, input bit rw, input bit mr);
        op = 3'(o); rd1 = 8'(a); rd2 = 8'(b2); imm = 8'(im); alusrc = src;
        dst = 3'(d); regwrite_in = rw; memtoreg_in = mr; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; rd1 = '0; rd2 = '0; imm = '0; alusrc = 1'b0;
        dst = '0; regwrite_in = 1'b0; memtoreg_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // One randomized cycle; entered and left at 1 time unit after a rising edge.
    task automatic rand_cycle(input bit drive, inout bit stall_prev, inout int prev_res);
        exp_t e;
        int   b;
        if (drive) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            op          = 3'($urandom_range(0, 7));
            rd1         = 8'($urandom);
            rd2         = 8'($urandom);
            imm         = 8'($urandom);
            alusrc      = 1'($urandom);
            dst         = 3'($urandom);
            regwrite_in = 1'($urandom);
            memtoreg_in = 1'($urandom);
            if ($urandom_range(0, 7) == 0) rd2 = rd1;
        end else begin
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(negedge clk);
        if (out_valid && stall_prev) chk("hold", result, prev_res);
        if (!out_ready) chk("rw_stalled", regwrite_out, 0);
        if (out_valid && out_ready) begin
            chk("q_nonempty", (q.size() > 0) ? 1 : 0, 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("r_res", result, e.res);
                chk("r_carry", carry, e.c);
                chk("r_zero", zero, (e.res == 0) ? 1 : 0);
                chk("r_wa", wa_out, e.wa);
                chk("r_rw", regwrite_out, e.rw);
                chk("r_mr", memtoreg_out, e.mr);
            end
        end
        if (in_valid && in_ready) begin
            b = alusrc ? int'(imm) : int'(rd2);
            model(int'(op), int'(rd1), b, e.res, e.c);
            e.wa = int'(dst); e.rw = int'(regwrite_in); e.mr = int'(memtoreg_in);
            q.push_back(e);
        end
        stall_prev = out_valid && !out_ready;
        prev_res   = int'(result);
        @(posedge clk); #1;
    endtask

    initial begin
        bit stall_prev;
        int prev_res;

        do_reset();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_busy", busy, 0);
        chk("rst_regwrite", regwrite_out, 0);
        chk("rst_zero", zero, 0);

        out_ready = 1'b1;
        send(0, 200, 100, 0, 0, 1, 1, 0);
        chk("add_res", result, 44);
        chk("add_carry", carry, 1);
        chk("add_zero", zero, 0);
        chk("add_valid", out_valid, 1);

        send(1, 5, 77, 5, 1, 2, 1, 1);
        chk("sub_res", result, 0);
        chk("sub_zero", zero, 1);
        chk("sub_carry", carry, 0);
        chk("sub_mr", memtoreg_out, 1);

        send(0, 3, 4, 0, 0, 5, 1, 0);
        out_ready = 1'b0;
        #1;
        chk("bp_res", result, 7);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_rw", regwrite_out, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("bp_res_held", result, 7);
        chk("bp_valid_held", out_valid, 1);
        out_ready = 1'b1;
        #1;
        chk("bp_rw_drain", regwrite_out, 1);
        chk("bp_wa", wa_out, 5);
        @(posedge clk); #1;
        chk("bp_cleared", out_valid, 0);
        chk("bp_rw_once", regwrite_out, 0);

        for (int i = 0; i < 5; i++) begin
            op = 3'd0; rd1 = 8'(i * 10); rd2 = 8'(i + 1); alusrc = 1'b0;
            dst = 3'(i); regwrite_in = 1'b1; in_valid = 1'b1;
            @(posedge clk); #1;
            chk("b2b_valid", out_valid, 1);
            chk("b2b_res", result, i * 11 + 1);
        end
        in_valid = 1'b0;

`ifdef ALU_MUL_EN
        send(7, 13, 11, 0, 0, 3, 1, 0);
        repeat (7) @(posedge clk);
        #1;
        chk("mul_busy", busy, 1);
        chk("mul_in_ready", in_ready, 0);
        chk("mul_not_yet", out_valid, 0);
        @(posedge clk); #1;
        chk("mul_valid", out_valid, 1);
        chk("mul_res", result, 143);
        chk("mul_busy_off", busy, 0);
        chk("mul_wa", wa_out, 3);
        send(7, 20, 0, 20, 1, 4, 1, 0);
        repeat (8) @(posedge clk);
        #1;
        chk("mul2_res", result, 144);
        chk("mul2_carry", carry, 0);

        send(7, 13, 11, 0, 0, 6, 1, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_in_ready", in_ready, 1);
        repeat (10) @(posedge clk);
        #1;
        chk("abort_no_stale", out_valid, 0);
        chk("abort_no_rw", regwrite_out, 0);
`else
        send(7, 99, 45, 0, 0, 2, 1, 0);
        chk("mov_res", result, 45);
        chk("mov_carry", carry, 0);
        chk("mov_busy", busy, 0);
        send(7, 99, 45, 0, 1, 2, 1, 0);
        chk("mov_imm_zero", zero, 1);
`endif

        do_reset();
        q.delete();
        stall_prev = 1'b0;
        prev_res   = 0;
        for (int c = 0; c < 1500; c++) rand_cycle(1'b1, stall_prev, prev_res);
        for (int c = 0; c < 20; c++) rand_cycle(1'b0, stall_prev, prev_res);
        chk("drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
